// File: rtl/awg_pkg.sv
// awg_pkg: shared AWG widths and the tuning-word helper used by phase_acc_gen and tri_gen
package awg_pkg;
    localparam int DAC_W   = 14;
    localparam int FREQ_W  = 12;
    localparam int PHASE_W = 8;
    localparam int AMP_W   = 8;
    function automatic logic [31:0] tuning_word(input logic [FREQ_W-1:0] freq, input int shift);
        return 32'(freq) << shift;
    endfunction
endpackage

// File: rtl/phase_acc_gen_if.sv
// phase_acc_gen_if: control codes in (en, state_freq, state_phase), phase count out (cnt, wrap)
interface phase_acc_gen_if;
    import awg_pkg::*;
    logic               en;
    logic [FREQ_W-1:0]  state_freq;
    logic [PHASE_W-1:0] state_phase;
    logic [DAC_W-1:0]   cnt;
    logic               wrap;
    modport master (output en, state_freq, state_phase, input cnt, wrap);
    modport slave  (input en, state_freq, state_phase, output cnt, wrap);
endinterface

// File: rtl/phase_acc_gen.sv
// phase_acc_gen: DDS phase accumulator; clk, rst (sync high), bus.slave: en/state_freq/state_phase in, cnt/wrap out
module phase_acc_gen
    import awg_pkg::*;
#(
    parameter int ACC_W      = 24,
    parameter int FREQ_SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst,
    phase_acc_gen_if.slave    bus
);
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   inc;
    logic [ACC_W-1:0]   off;
    logic [ACC_W-1:0]   sum;
    logic [ACC_W:0]     nxt;
    logic [FREQ_W-1:0]  freq_act;
    logic [PHASE_W-1:0] phase_act;
    logic [DAC_W-1:0]   cnt_q;
    logic               carry_q;
    logic               wrap_q;
    assign inc = ACC_W'(tuning_word(freq_act, FREQ_SHIFT));
    assign off = {phase_act, {(ACC_W-PHASE_W){1'b0}}};
    assign nxt = {1'b0, acc} + {1'b0, inc};
    assign sum = acc + off;
    assign bus.cnt  = cnt_q;
    assign bus.wrap = wrap_q;
    // cnt shows the pre-increment acc one stage later, so the carry is delayed one
    // stage too: wrap lines up with the first post-wrap cnt value
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            freq_act  <= '0;
            phase_act <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            wrap_q    <= 1'b0;
        end else if (!bus.en) begin
            acc       <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            wrap_q    <= 1'b0;
            freq_act  <= bus.state_freq;
            phase_act <= bus.state_phase;
        end else begin
            acc     <= nxt[ACC_W-1:0];
            cnt_q   <= sum[ACC_W-1 -: DAC_W];
            carry_q <= nxt[ACC_W];
            wrap_q  <= carry_q;
            if (nxt[ACC_W]) begin
                freq_act  <= bus.state_freq;
                phase_act <= bus.state_phase;
            end
        end
    end
endmodule

// File: tb/tb_phase_acc_gen.sv
// tb_phase_acc_gen: directed checks of phase_acc_gen with ACC_W=16, FREQ_SHIFT=4 (cnt = sum[15:2])
module tb_phase_acc_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    phase_acc_gen_if bus ();
    phase_acc_gen #(.ACC_W(16), .FREQ_SHIFT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic start(input logic [11:0] f, input logic [7:0] p);
        bus.en = 1'b0;
        bus.state_freq = f;
        bus.state_phase = p;
        tick();
        bus.en = 1'b1;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        bus.en = 1'b1;
        bus.state_freq = 12'h100;
        bus.state_phase = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.cnt !== 14'h0 || bus.wrap !== 1'b0) begin
                failures++;
                $display("FAIL reset cyc%0d cnt=%h wrap=%b exp cnt=0000 wrap=0", i, bus.cnt, bus.wrap);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.cnt !== 14'h0 || bus.wrap !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc%0d cnt=%h wrap=%b exp cnt=0000 wrap=0", i, bus.cnt, bus.wrap);
            end
        end
    endtask
    task automatic test_basic_ramp;
        logic [13:0] ec;
        start(12'h100, 8'h00);
        for (int k = 1; k <= 34; k++) begin
            tick();
            ec = 14'(((k - 1) % 16) * 14'h400);
            checks++;
            if (bus.cnt !== ec || bus.wrap !== (k == 17 || k == 33)) begin
                failures++;
                $display("FAIL ramp k%0d cnt=%h wrap=%b exp cnt=%h wrap=%b", k, bus.cnt, bus.wrap, ec, (k == 17 || k == 33));
            end
        end
    endtask
    task automatic test_phase_offset;
        logic [13:0] ec;
        start(12'h100, 8'h80);
        for (int k = 1; k <= 20; k++) begin
            tick();
            ec = 14'((((k - 1) % 16) * 14'h400) + 14'h2000);
            checks++;
            if (bus.cnt !== ec || bus.wrap !== (k == 17)) begin
                failures++;
                $display("FAIL phase k%0d cnt=%h wrap=%b exp cnt=%h wrap=%b", k, bus.cnt, bus.wrap, ec, (k == 17));
            end
        end
    endtask
    task automatic test_boundary_update;
        logic [13:0] ec;
        start(12'h100, 8'h00);
        for (int k = 1; k <= 34; k++) begin
            tick();
            ec = (k <= 16) ? 14'((k - 1) * 14'h400) : 14'(((k - 17) % 8) * 14'h800);
            checks++;
            if (bus.cnt !== ec || bus.wrap !== (k == 17 || k == 25 || k == 33)) begin
                failures++;
                $display("FAIL boundary k%0d cnt=%h wrap=%b exp cnt=%h wrap=%b", k, bus.cnt, bus.wrap, ec, (k == 17 || k == 25 || k == 33));
            end
            if (k == 5) bus.state_freq = 12'h200;
        end
    endtask
    task automatic test_stop_mid_period;
        start(12'h100, 8'h40);
        for (int k = 1; k <= 3; k++) tick();
        checks++;
        if (bus.cnt !== 14'h1800) begin
            failures++;
            $display("FAIL stop_pre cnt=%h exp cnt=1800", bus.cnt);
        end
        bus.en = 1'b0;
        tick();
        checks++;
        if (bus.cnt !== 14'h0 || bus.wrap !== 1'b0) begin
            failures++;
            $display("FAIL stop_idle cnt=%h wrap=%b exp cnt=0000 wrap=0", bus.cnt, bus.wrap);
        end
        bus.en = 1'b1;
        tick();
        checks++;
        if (bus.cnt !== 14'h1000 || bus.wrap !== 1'b0) begin
            failures++;
            $display("FAIL stop_restart1 cnt=%h wrap=%b exp cnt=1000 wrap=0", bus.cnt, bus.wrap);
        end
        tick();
        checks++;
        if (bus.cnt !== 14'h1400 || bus.wrap !== 1'b0) begin
            failures++;
            $display("FAIL stop_restart2 cnt=%h wrap=%b exp cnt=1400 wrap=0", bus.cnt, bus.wrap);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.cnt !== 14'h0 || bus.wrap !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset cnt=%h wrap=%b exp cnt=0000 wrap=0", bus.cnt, bus.wrap);
        end
    endtask
    task automatic test_zero_and_max_freq;
        logic [13:0] ec;
        start(12'h000, 8'h40);
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (bus.cnt !== 14'h1000 || bus.wrap !== 1'b0) begin
                failures++;
                $display("FAIL zero_freq k%0d cnt=%h wrap=%b exp cnt=1000 wrap=0", k, bus.cnt, bus.wrap);
            end
            if (k == 2) bus.state_freq = 12'h100;
        end
        start(12'hFFF, 8'h00);
        for (int k = 1; k <= 10; k++) begin
            tick();
            ec = (k == 1) ? 14'h0 : 14'(16384 - 4 * (k - 1));
            checks++;
            if (bus.cnt !== ec || bus.wrap !== (k >= 3)) begin
                failures++;
                $display("FAIL max_freq k%0d cnt=%h wrap=%b exp cnt=%h wrap=%b", k, bus.cnt, bus.wrap, ec, (k >= 3));
            end
        end
    endtask
    initial begin
        bus.en = 1'b0;
        bus.state_freq = '0;
        bus.state_phase = '0;
        test_reset();
        test_basic_ramp();
        test_phase_offset();
        test_boundary_update();
        test_stop_mid_period();
        test_zero_and_max_freq();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
